// File: rtl/fifo_nibble_packer.sv
// fifo_nibble_packer: drains nibbles from a 4-bit FIFO read port and packs
// NIBBLES of them into one wide word, presented on a valid/ready master port.
// A flush pulse pushes out a partially filled word with its nibble count.
module fifo_nibble_packer #(
   parameter int DATA_W  = 4,
   parameter int NIBBLES = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      fifo_empty,
   input  logic [DATA_W-1:0]         fifo_dout,
   output logic                      fifo_rd,
   input  logic                      flush,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [DATA_W*NIBBLES-1:0] m_data,
   output logic [$clog2(NIBBLES):0]  m_count,
   output logic                      busy
);

   localparam int WORD_W = DATA_W * NIBBLES;
   localparam int CW     = $clog2(NIBBLES) + 1;
   localparam logic [CW-1:0] FULL = CW'(NIBBLES);

   // FILL: gathering nibbles; DRAIN: flush waiting on an in-flight read;
   // HOLD: pack holds a finished (full or partial) word but the output is busy
   typedef enum logic [1:0] {FILL, DRAIN, HOLD} state_t;

   state_t            state;
   logic [WORD_W-1:0] pack;
   logic [CW-1:0]     idx;
   logic              pend;
   logic              flush_req;

   logic [WORD_W-1:0] pack_cap;
   logic [CW-1:0]     idx_cap;
   logic              word_done;
   logic              slot_free;

   // Pack register as it looks after this cycle's pending nibble lands
   always_comb begin
      pack_cap = pack;
      for (int i = 0; i < NIBBLES; i++) begin
         if (pend && (idx == CW'(i)))
            pack_cap[i*DATA_W +: DATA_W] = fifo_dout;
      end
   end

   // idx_cap doubles as "captured + in flight" for the read-issue limit
   assign idx_cap   = idx + CW'(pend);
   assign word_done = pend && (idx_cap == FULL);
   assign slot_free = !m_valid || m_ready;

   // Reads stop once the word is fully claimed, while flushing, or outside FILL
   assign fifo_rd = !rst && !fifo_empty && (state == FILL) && !flush_req &&
                    (idx_cap < FULL);

   assign busy = (idx != '0) || pend || flush_req || (state != FILL);

   // Capture, flush handling and output register, all in one state machine
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= FILL;
         pack      <= '0;
         idx       <= '0;
         pend      <= 1'b0;
         flush_req <= 1'b0;
         m_valid   <= 1'b0;
         m_data    <= '0;
         m_count   <= '0;
      end else begin
         pend <= fifo_rd;
         // accepted word leaves the slot unless something reloads it below
         if (m_valid && m_ready)
            m_valid <= 1'b0;

         case (state)
            HOLD: begin
               if (flush)
                  flush_req <= 1'b1;
               if (slot_free) begin
                  m_valid <= 1'b1;
                  m_data  <= pack;
                  m_count <= idx;
                  pack    <= '0;
                  idx     <= '0;
                  state   <= FILL;
               end
            end

            default: begin
               if (word_done) begin
                  // a flush on this edge finds idx=0 afterwards and is dropped
                  if (flush)
                     flush_req <= 1'b1;
                  if (slot_free) begin
                     m_valid <= 1'b1;
                     m_data  <= pack_cap;
                     m_count <= FULL;
                     pack    <= '0;
                     idx     <= '0;
                     state   <= FILL;
                  end else begin
                     pack  <= pack_cap;
                     idx   <= idx_cap;
                     state <= HOLD;
                  end
               end else if (flush_req && !pend) begin
                  // nothing in flight: emit the partial word or drop the request
                  flush_req <= 1'b0;
                  state     <= FILL;
                  if (idx != '0) begin
                     if (slot_free) begin
                        m_valid <= 1'b1;
                        m_data  <= pack;
                        m_count <= idx;
                        pack    <= '0;
                        idx     <= '0;
                     end else begin
                        state <= HOLD;
                     end
                  end
               end else begin
                  pack <= pack_cap;
                  idx  <= idx_cap;
                  if (flush)
                     flush_req <= 1'b1;
                  if (flush_req && pend)
                     state <= DRAIN;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_nibble_packer.sv
// Bench for fifo_nibble_packer: FIFO model, word scoreboard, directed timing
// cases and randomized bursts with random backpressure.
module tb_fifo_nibble_packer;

   localparam int DATA_W  = 4;
   localparam int NIBBLES = 4;
   localparam int WW      = DATA_W * NIBBLES;
   localparam int CW      = $clog2(NIBBLES) + 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              fifo_empty = 1'b1;
   logic [DATA_W-1:0] fifo_dout = '0;
   logic              fifo_rd;
   logic              flush = 1'b0;
   logic              m_valid;
   logic [WW-1:0]     m_data;
   logic [CW-1:0]     m_count;
   logic              busy;
   logic              ready_val = 1'b0;
   logic              rand_en = 1'b0;
   logic              rnd_bit = 1'b0;
   wire               m_ready = rand_en ? rnd_bit : ready_val;

   logic [DATA_W-1:0]    q[$];      // FIFO contents
   logic [CW+WW-1:0]     exp_q[$];  // expected {count, data} words
   int n_chk  = 0;
   int n_pass = 0;

   logic              prev_stall = 1'b0;
   logic [CW+WW-1:0]  prev_word = '0;

   always #5 clk = ~clk;

   fifo_nibble_packer #(.DATA_W(DATA_W), .NIBBLES(NIBBLES)) dut (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
      .fifo_rd(fifo_rd), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data), .m_count(m_count), .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h expected=%h", tag, act, exp);
   endtask

   // 16-deep FIFO model with registered read data
   always @(posedge clk) begin
      if (fifo_rd && q.size() > 0) begin
         fifo_dout  <= q.pop_front();
         fifo_empty <= (q.size() == 0);
      end
   end

   always @(posedge clk) begin
      #1 rnd_bit = 1'($urandom_range(0, 1));
   end

   // Scoreboard: accepted words in order; stalled words must stay put
   always @(negedge clk) begin
      if (rst) begin
         prev_stall <= 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_valid", 32'(m_valid), 32'd1);
            chk("hold_word", 32'({m_count, m_data}), 32'(prev_word));
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) chk("extra_word", 32'({m_count, m_data}), 32'hFFFF_FFFF);
            else                   chk("word", 32'({m_count, m_data}), 32'(exp_q.pop_front()));
         end
         prev_stall <= m_valid && !m_ready;
         prev_word  <= {m_count, m_data};
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DATA_W-1:0] v);
      q.push_back(v);
      fifo_empty = 1'b0;
   endtask

   task automatic expect_word(input int cnt, input logic [WW-1:0] w);
      exp_q.push_back({CW'(cnt), w});
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      cyc(1);
      flush = 1'b0;
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         cyc(1);
         n++;
      end
      chk(tag, exp_q.size(), 0);
   endtask

   initial begin
      logic [11:0] rdv, mvv;
      logic [CW+WW-1:0] w5, w10;
      logic seen_rd, seen_mv;

      // ---- reset values ----
      #1;
      chk("rst_valid", 32'(m_valid), 0);
      chk("rst_count", 32'(m_count), 0);
      chk("rst_rd", 32'(fifo_rd), 0);
      chk("rst_busy", 32'(busy), 0);
      cyc(3);
      rst = 1'b0;

      // ---- streaming 1..8, m_ready=1 ----
      ready_val = 1'b1;
      expect_word(4, 16'h4321);
      expect_word(4, 16'h8765);
      for (int i = 1; i <= 8; i++) push(4'(i));
      rdv = '0; mvv = '0; w5 = '0; w10 = '0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         rdv[c] = fifo_rd;
         mvv[c] = m_valid;
         if (c == 5)  w5  = {m_count, m_data};
         if (c == 10) w10 = {m_count, m_data};
      end
      @(posedge clk); #1;
      chk("stream_rd", 32'(rdv), 32'h1EF);
      chk("stream_valid", 32'(mvv), 32'h420);
      chk("stream_w5", 32'(w5), 32'({3'd4, 16'h4321}));
      chk("stream_w10", 32'(w10), 32'({3'd4, 16'h8765}));
      wait_drain("stream_drain", 20);

      // ---- backpressure 1..C ----
      ready_val = 1'b0;
      expect_word(4, 16'h4321);
      expect_word(4, 16'h8765);
      expect_word(4, 16'hCBA9);
      for (int i = 1; i <= 12; i++) push(4'(i));
      cyc(25);
      chk("bp_valid", 32'(m_valid), 1);
      chk("bp_data", 32'(m_data), 32'h4321);
      chk("bp_rd", 32'(fifo_rd), 0);
      chk("bp_fifo_left", q.size(), 4);
      ready_val = 1'b1;
      wait_drain("bp_drain", 60);

      // ---- partial flush A,B,C then a flush with nothing buffered ----
      expect_word(3, 16'h0CBA);
      push(4'hA); push(4'hB); push(4'hC);
      cyc(8);
      pulse_flush();
      wait_drain("partial_drain", 20);
      cyc(3);
      pulse_flush();
      seen_mv = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         seen_mv |= m_valid;
      end
      @(posedge clk); #1;
      chk("flush_empty_none", 32'(seen_mv), 0);
      chk("flush_empty_busy", 32'(busy), 0);

      // ---- flush with a read still pending ----
      expect_word(2, 16'h0065);
      push(4'h5); push(4'h6);
      cyc(2);
      pulse_flush();
      wait_drain("pend_flush_drain", 20);

      // ---- flush on the edge that captures the 4th nibble ----
      expect_word(4, 16'h4321);
      for (int i = 1; i <= 4; i++) push(4'(i));
      cyc(4);
      pulse_flush();
      wait_drain("coinc_drain", 20);
      cyc(4);
      chk("coinc_busy", 32'(busy), 0);

      // ---- asynchronous reset mid-word ----
      ready_val = 1'b0;
      for (int i = 1; i <= 6; i++) push(4'(i));
      cyc(12);
      chk("pre_rst_valid", 32'(m_valid), 1);
      chk("pre_rst_busy", 32'(busy), 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", 32'(m_valid), 0);
      chk("arst_data", 32'(m_data), 0);
      chk("arst_count", 32'(m_count), 0);
      chk("arst_rd", 32'(fifo_rd), 0);
      chk("arst_busy", 32'(busy), 0);
      q.delete();
      exp_q.delete();
      fifo_empty = 1'b1;
      cyc(2);
      rst = 1'b0;
      seen_rd = 1'b0; seen_mv = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         seen_rd |= fifo_rd;
         seen_mv |= m_valid;
      end
      @(posedge clk); #1;
      chk("idle_rd", 32'(seen_rd), 0);
      chk("idle_valid", 32'(seen_mv), 0);

      // ---- random bursts, random gaps, random backpressure, final flush ----
      rand_en = 1'b1;
      for (int it = 0; it < 25; it++) begin
         int k, cnt, n;
         logic [WW-1:0] w;
         logic [DATA_W-1:0] v[$];
         k = $urandom_range(1, 11);
         for (int i = 0; i < k; i++) v.push_back(4'($urandom_range(0, 15)));
         // reference: chop the nibble stream into words, remainder flushed
         cnt = 0; w = '0;
         foreach (v[i]) begin
            w = w | (WW'(v[i]) << (DATA_W * cnt));
            cnt++;
            if (cnt == NIBBLES) begin
               expect_word(cnt, w);
               cnt = 0; w = '0;
            end
         end
         if (cnt > 0) expect_word(cnt, w);
         foreach (v[i]) begin
            push(v[i]);
            cyc($urandom_range(1, 3));
         end
         n = 0;
         while (q.size() != 0 && n < 200) begin
            cyc(1);
            n++;
         end
         chk("rand_fifo_empty", q.size(), 0);
         cyc(3);
         pulse_flush();
         wait_drain("rand_drain", 200);
      end
      rand_en = 1'b0;
      ready_val = 1'b1;
      cyc(6);
      chk("final_busy", 32'(busy), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fifo_nibble_packer.md
# fifo_nibble_packer

Read-side companion for the 16-deep, 4-bit synchronous FIFO. It drains nibbles from the FIFO read port, packs NIBBLES consecutive nibbles into one wide word (first nibble in the least-significant position), and presents each word on a valid/ready master interface. A flush request emits a partially filled word. It sits between the FIFO and any wide-word consumer.

## Interface
- DATA_W, 4: FIFO data width.
- NIBBLES, 4: number of FIFO entries packed per output word. Legal values are 2 to 8.
- clk  in  1  Clock. All logic is on the rising edge.
- rst  in  1  Reset. **One clock; reset is asynchronous and active-high.**
- fifo_empty  in  1  FIFO empty flag.
- fifo_dout  in  DATA_W  FIFO registered read data. It is valid in the cycle after a read is accepted.
- fifo_rd  out  1  Read strobe. At integration it maps to the FIFO read condition.
- flush  in  1  Single-cycle pulse requesting emission of the partial word.
- m_valid  out  1  Output word valid.
- m_ready  in  1  Consumer accepts the output word.
- m_data  out  DATA_W*NIBBLES  Packed word.
- m_count  out  $clog2(NIBBLES)+1  Number of valid nibbles in m_data, from 1 to NIBBLES.
- busy  out  1  High when idx≠0, pend=1, flush_req=1, or state≠FILL.

## Operation
- **Internal state:**
  - pack register.
  - idx: number of nibbles captured.
  - pend: a read was issued last cycle.
  - flush_req latch.
  - FSM with states FILL, DRAIN and HOLD.
- **Read issue (combinational):** fifo_rd = !rst && !fifo_empty && state==FILL && !flush_req && (idx+pend < NIBBLES).
  - A read is never issued when empty, so an underflow is impossible.
- **Capture:**
  - pend <= fifo_rd.
  - When pend=1, fifo_dout is written into pack[idx*DATA_W +: DATA_W] and idx increments.
- **Word complete:** occurs when the capture brings idx to NIBBLES.
  - If (!m_valid || m_ready): load m_data=pack with that nibble, m_count=NIBBLES, m_valid=1, and clear idx and pack.
  - Otherwise go to HOLD.
- **HOLD:**
  - No reads are issued.
  - Transfer when (!m_valid || m_ready), then return to FILL.
- **Flush:**
  - A flush pulse sets flush_req, and further reads stop.
  - FILL→DRAIN while pend=1. DRAIN is left once the pending nibble is captured.
  - With flush_req set and pend=0:
    - If idx>0: emit pack with m_count=idx; unused upper nibbles are 0.
    - If idx=0: drop the request and emit nothing.
  - flush_req clears on emit or drop.
  - The partial emit obeys the same output-slot rule as a full word (waits in HOLD).
- **Flush edge cases:**
  - Flush in the same cycle as word completion: the full word is emitted with count NIBBLES, then the flush sees idx=0 and is dropped.
  - Flush while flush_req is already set has no effect.
  - Flush in HOLD is latched and applied after the held word transfers.
- **Output register:** m_data and m_count are stable while m_valid && !m_ready. m_valid drops after acceptance unless a new word loads on the same edge.
- **Ordering:** nibble order is strictly FIFO order. No nibble is lost or duplicated except on reset.

## Timing
- **Reset values** (immediate on rst, asynchronous): m_valid=0, m_data=0, m_count=0, fifo_rd=0, busy=0, idx=0, pend=0, flush_req=0, state=FILL.
- **Reset mid-word** discards the partial pack contents and any pending nibble.
- **Read latency:** a read sampled at edge En delivers data captured at edge En+1.
- **Word latency:** the last fifo_rd is high in cycle k, and m_valid goes high in cycle k+2.
- **Sustained throughput** (FIFO never empty, m_ready=1):
  - fifo_rd is high for NIBBLES cycles, then there is a 1-cycle bubble.
  - One word every NIBBLES+1 cycles.
- **Back-to-back words:** accept and load on the same edge keep m_valid high continuously.
- **Empty mid-word:** fifo_rd deasserts. The partial word waits indefinitely until more data arrives or a flush.

## Test plan
1. **Reset:** assert rst asynchronously mid-cycle → all outputs 0 before the next edge. After release with fifo_empty=1 → fifo_rd=0 and m_valid=0 indefinitely.
2. **Streaming:** FIFO holds 1,2,3,4,5,6,7,8, m_ready=1, first fifo_rd in cycle 0.
   - fifo_rd is high in cycles 0–3 and 5–8.
   - m_data=16'h4321 with m_count=4 in cycle 5.
   - m_data=16'h8765 in cycle 10.
3. **Backpressure:** m_ready=0 with 12 nibbles 1..C.
   - 16'h4321 is held in the output with m_data stable.
   - 16'h8765 waits in HOLD and fifo_rd stays 0, leaving 4 entries in the FIFO.
   - Raise m_ready → 16'h4321, 16'h8765, 16'hCBA9 are emitted in order.
4. **Partial flush:** nibbles A,B,C, then empty, then flush.
   - m_data=16'h0CBA with m_count=3.
   - A second flush with idx=0 produces no m_valid.
5. **Flush with pending read:** flush in the cycle after the 2nd fifo_rd (nibbles 5,6) → m_data=16'h0065 with m_count=2.
6. **Flush coinciding with 4th capture:** → a single word with m_count=4. No zero-count word appears, and busy returns to 0.
